// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and default width shared by the sequential ALU.
package alu_pkg;
    localparam int ALU_WIDTH = 7;
    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_ROR1 = 3'd1;
    localparam logic [2:0] OP_NOP  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_RORN = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle ops 0-5 with flag generation.
// Build option ALU_SAT_EN: saturate ADD to all ones on carry out.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             flag_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] add_res;
    assign sum = {1'b0, a_i} + {1'b0, b_i};
`ifdef ALU_SAT_EN
    assign add_res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    assign add_res = sum[WIDTH-1:0];
`endif
    // Anything outside 0-5 (op 6 with zero shift) falls through to pass a.
    always_comb begin
        result_o = op_i == OP_NOT  ? ~a_i :
                   op_i == OP_ROR1 ? {a_i[0], a_i[WIDTH-1:1]} :
                   op_i == OP_AND  ? a_i & b_i :
                   op_i == OP_OR   ? a_i | b_i :
                   op_i == OP_ADD  ? add_res : a_i;
        flag_o   = op_i == OP_ADD ? sum[WIDTH] : result_o == '0;
    end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked 7-bit ALU with iterative rotate-by-N and shift-add multiply.
// Build option ALU_SAT_EN (see alu_comb_core) selects saturating ADD.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int MUL_STEPS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag
);
    localparam int MAXS = MUL_STEPS > 7 ? MUL_STEPS : 7;
    localparam int CW   = $clog2(MAXS + 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, result_q, rot_d, core_res;
    logic [2:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic               flag_q, in_ready_q, out_valid_q, core_flag, last;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (a),
        .b_i      (b),
        .op_i     (op),
        .result_o (core_res),
        .flag_o   (core_flag)
    );

    // Multiply consumes b_q LSB-first while the multiplicand shifts left.
    always_comb begin
        rot_d = {a_q[0], a_q[WIDTH-1:1]};
        acc_d = acc_q + (b_q[0] ? mcand_q : '0);
        last  = cnt_q == CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a;
                    b_q        <= b;
                    op_q       <= op;
                    mcand_q    <= {{WIDTH{1'b0}}, a};
                    acc_q      <= '0;
                    in_ready_q <= 1'b0;
                    if (op == OP_MUL) begin
                        state_q <= EXEC;
                        cnt_q   <= CW'(MUL_STEPS);
                    end else if (op == OP_RORN && b[2:0] != 3'd0) begin
                        state_q <= EXEC;
                        cnt_q   <= CW'(b[2:0]);
                    end else begin
                        state_q     <= DONE;
                        result_q    <= core_res;
                        flag_q      <= core_flag;
                        out_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q   <= acc_d;
                        mcand_q <= mcand_q << 1;
                        b_q     <= b_q >> 1;
                    end else begin
                        a_q <= rot_d;
                    end
                    if (last) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= op_q == OP_MUL ? acc_d[WIDTH-1:0] : rot_d;
                        flag_q      <= op_q == OP_MUL ? |acc_d[2*WIDTH-1:WIDTH] : rot_d == '0;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag      = flag_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed self-checking bench for alu_seq_unit.
module tb_alu_seq_unit;
    logic       clk = 0, reset = 0, in_valid = 0, out_ready = 0;
    logic       in_ready, out_valid, flag;
    logic [6:0] a = '0, b = '0, result;
    logic [2:0] op = '0;
    int         errors = 0, checks = 0;

    alu_seq_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag(flag)
    );

    always #5 clk = ~clk;

    // Drive one accepted op; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [6:0] x, input logic [6:0] y);
        @(negedge clk);
        in_valid = 1; op = o; a = x; b = y;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 7'd0 || flag !== 1'b0) begin errors++; $display("FAIL reset_result got=%b/%b exp=0000000/0", result, flag); end
        reset = 1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_not();
        issue(3'd0, 7'b0101010, 7'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL not_latency out_valid got=%b exp=1", out_valid); end
        checks++; if (result !== 7'b1010101 || flag !== 1'b0) begin errors++; $display("FAIL not_result got=%b/%b exp=1010101/0", result, flag); end
        drain();
    endtask

    task automatic test_ror1();
        issue(3'd1, 7'b0001101, 7'd0);
        checks++; if (result !== 7'b1000110 || flag !== 1'b0) begin errors++; $display("FAIL ror1_result got=%b/%b exp=1000110/0", result, flag); end
        drain();
        issue(3'd1, 7'd0, 7'd0);
        checks++; if (result !== 7'd0 || flag !== 1'b1) begin errors++; $display("FAIL ror1_zero got=%b/%b exp=0000000/1", result, flag); end
        drain();
    endtask

    task automatic test_add();
        logic [6:0] exp_r;
`ifdef ALU_SAT_EN
        exp_r = 7'b1111111;
`else
        exp_r = 7'b0000000;
`endif
        issue(3'd5, 7'b1111111, 7'b0000001);
        checks++; if (result !== exp_r || flag !== 1'b1) begin errors++; $display("FAIL add_carry got=%b/%b exp=%b/1", result, flag, exp_r); end
        drain();
        issue(3'd5, 7'd20, 7'd22);
        checks++; if (result !== 7'd42 || flag !== 1'b0) begin errors++; $display("FAIL add_plain got=%0d/%b exp=42/0", result, flag); end
        drain();
    endtask

    task automatic test_rorn();
        int n;
        issue(3'd6, 7'b0000001, 7'd3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rorn_exec%0d in_ready/out_valid got=%b/%b exp=0/0", i, in_ready, out_valid); end
            a = 7'h55; op = 3'd0;
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rorn_latency out_valid got=%b exp=1", out_valid); end
        checks++; if (result !== 7'b0010000 || flag !== 1'b0) begin errors++; $display("FAIL rorn_result got=%b/%b exp=0010000/0", result, flag); end
        drain();
        issue(3'd6, 7'b1011001, 7'd7);
        wait_out(n);
        checks++; if (n !== 7 || result !== 7'b1011001) begin errors++; $display("FAIL rorn7 lat=%0d res=%b exp=7/1011001", n, result); end
        drain();
        issue(3'd6, 7'b1011001, 7'd8);
        checks++; if (out_valid !== 1'b1 || result !== 7'b1011001) begin errors++; $display("FAIL rorn0 ov=%b res=%b exp=1/1011001", out_valid, result); end
        drain();
    endtask

    task automatic test_mul();
        int n;
        issue(3'd7, 7'd5, 7'd6);
        wait_out(n);
        checks++; if (n !== 7) begin errors++; $display("FAIL mul_latency got=%0d exp=7", n); end
        checks++; if (result !== 7'b0011110 || flag !== 1'b0) begin errors++; $display("FAIL mul_5x6 got=%b/%b exp=0011110/0", result, flag); end
        drain();
        issue(3'd7, 7'd12, 7'd11);
        wait_out(n);
        checks++; if (result !== 7'b0000100 || flag !== 1'b1) begin errors++; $display("FAIL mul_12x11 got=%b/%b exp=0000100/1", result, flag); end
        drain();
    endtask

    task automatic test_backpressure();
        issue(3'd2, 7'b0110011, 7'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; a = 7'd0; op = 3'd0;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 7'b0110011) begin errors++; $display("FAIL bp_hold%0d ov/ir/res got=%b/%b/%b exp=1/0/0110011", i, out_valid, in_ready, result); end
            @(negedge clk);
        end
        in_valid = 0;
        drain();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release ir/ov got=%b/%b exp=1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(3'd7, 7'd5, 7'd6);
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || result !== 7'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset ov/res/ir got=%b/%b/%b exp=0/0000000/1", out_valid, result, in_ready); end
        reset = 1;
        issue(3'd0, 7'd0, 7'd0);
        wait_out(n);
        checks++; if (n !== 0 || result !== 7'b1111111 || flag !== 1'b0) begin errors++; $display("FAIL after_reset lat=%0d res=%b/%b exp=0/1111111/0", n, result, flag); end
        drain();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1; out_ready = 1; op = 3'd3; a = 7'b1100110; b = 7'b1010101;
        @(negedge clk);
        op = 3'd4; a = 7'd0; b = 7'd0;
        checks++; if (out_valid !== 1'b1 || result !== 7'b1000100 || flag !== 1'b0) begin errors++; $display("FAIL b2b_and ov/res/flag got=%b/%b/%b exp=1/1000100/0", out_valid, result, flag); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap ov/ir got=%b/%b exp=0/1", out_valid, in_ready); end
        @(negedge clk);
        in_valid = 0; out_ready = 0;
        checks++; if (out_valid !== 1'b1 || result !== 7'd0 || flag !== 1'b1) begin errors++; $display("FAIL b2b_or ov/res/flag got=%b/%b/%b exp=1/0000000/1", out_valid, result, flag); end
        drain();
    endtask

    initial begin
        test_reset();
        test_not();
        test_ror1();
        test_add();
        test_rorn();
        test_mul();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
